// File: rtl/dither_pkg.sv
// Shared definitions for the ordered-dither stage and its reconstruction.
package dither_pkg;

  // Thresholds of the 2x2 ordered-dither matrix, indexed by {vc[0], hc[0]}
  localparam logic [7:0] BAYER_T00 = 8'd32;
  localparam logic [7:0] BAYER_T01 = 8'd160;
  localparam logic [7:0] BAYER_T10 = 8'd224;
  localparam logic [7:0] BAYER_T11 = 8'd96;

  typedef logic [2:0]  win_cnt_t;
  typedef logic [10:0] coord_t;

  // Number of window taps that lie inside the frame
  typedef enum logic [1:0] {
    Taps1,
    Taps2,
    Taps4
  } taps_e;

  function automatic taps_e taps_for(logic hc_zero, logic vc_zero);
    if (hc_zero && vc_zero) begin
      return Taps1;
    end else if (hc_zero || vc_zero) begin
      return Taps2;
    end
    return Taps4;
  endfunction

  // Scale an on-count to grey for 2- and 4-tap windows, saturating at 255
  function automatic logic [7:0] sat_scale(win_cnt_t n, taps_e taps);
    logic [9:0] prod;
    prod = '0;
    unique case (taps)
      Taps4:   prod = {1'b0, n, 6'b0};
      Taps2:   prod = {n, 7'b0};
      default: prod = '0;
    endcase
    return (prod > 10'd255) ? 8'hff : prod[7:0];
  endfunction

endpackage

// File: rtl/dither_reconstruct_if.sv
// Pixel-stream bus between the dither stage and the reconstruction block.
interface dither_reconstruct_if;
  import dither_pkg::*;

  logic       pix_valid;
  coord_t     hc;
  coord_t     vc;
  logic [7:0] pixel_in;
  logic       out_valid;
  coord_t     hc_out;
  coord_t     vc_out;
  logic [7:0] gray_out;

  modport master (
    output pix_valid, hc, vc, pixel_in,
    input  out_valid, hc_out, vc_out, gray_out
  );

  modport slave (
    input  pix_valid, hc, vc, pixel_in,
    output out_valid, hc_out, vc_out, gray_out
  );

endinterface

// File: rtl/dither_linebuf.sv
// One-bit-wide line buffer holding the decoded bits of the previous line.
// Single synchronous port; the old contents are returned on the cycle they are overwritten.
module dither_linebuf #(
  parameter int unsigned Depth = 640,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic             wdata_i,
  output logic             rdata_o
);

  logic mem_q [Depth];
  logic rdata_q;

  // Read-before-write access; rdata holds between accesses
  always_ff @(posedge clk) begin
    if (we_i) begin
      rdata_q       <= mem_q[addr_i];
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dither_reconstruct.sv
// Rebuilds a grey estimate from a 2x2 ordered-dither stream by counting the on
// pixels in the 2x2 window ending at each pixel. Two-stage pipeline, 1 pixel/clk.
module dither_reconstruct
  import dither_pkg::*;
#(
  parameter int unsigned LINE_W = 640,
  parameter logic [7:0]  THRESH = 8'd128,
  parameter logic [7:0]  ON     = 8'd255,
  parameter logic [7:0]  OFF    = 8'd0
) (
  input logic           clk,
  input logic           reset,
  dither_reconstruct_if.slave bus
);

  localparam int unsigned AddrW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  logic accept;
  logic bit_in;
  logic above_raw;

  // Pixels beyond the active line never touch the buffer or the pipeline
  assign accept = bus.pix_valid && !reset && (32'(bus.hc) < LINE_W);
  assign bit_in = (bus.pixel_in >= THRESH);

  dither_linebuf #(
    .Depth (LINE_W),
    .AddrW (AddrW)
  ) u_linebuf (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (bus.hc[AddrW-1:0]),
    .wdata_i (bit_in),
    .rdata_o (above_raw)
  );

  // Tap history and S1 stage; above arrives from the line buffer output
  logic   prev_b_q, prev_b_d;
  logic   have_prev_q, have_prev_d;
  logic   s1_valid_q, s1_valid_d;
  logic   s1_b_q, s1_b_d;
  logic   s1_left_q, s1_left_d;
  logic   s1_al_q, s1_al_d;
  coord_t s1_hc_q, s1_hc_d;
  coord_t s1_vc_q, s1_vc_d;

  // S2 / output stage
  logic       out_valid_q, out_valid_d;
  logic [7:0] gray_q, gray_d;
  coord_t     hc_out_q, hc_out_d;
  coord_t     vc_out_q, vc_out_d;

  // S1 next state: capture the pixel and its left / above-left taps
  always_comb begin
    prev_b_d    = prev_b_q;
    have_prev_d = have_prev_q;
    s1_valid_d  = accept;
    s1_b_d      = s1_b_q;
    s1_left_d   = s1_left_q;
    s1_al_d     = s1_al_q;
    s1_hc_d     = s1_hc_q;
    s1_vc_d     = s1_vc_q;
    if (accept) begin
      s1_b_d      = bit_in;
      s1_hc_d     = bus.hc;
      s1_vc_d     = bus.vc;
      s1_left_d   = prev_b_q;
      // Buffer output still holds the previous pixel's above bit until this edge
      s1_al_d     = have_prev_q & above_raw;
      prev_b_d    = bit_in;
      have_prev_d = 1'b1;
    end
  end

  logic       hc_zero, vc_zero;
  logic       above_m, left_m, al_m;
  win_cnt_t   win_n;
  taps_e      taps;
  logic [7:0] gray_calc;

  // S2 next state: mask out-of-frame taps, count, scale
  always_comb begin
    hc_zero   = (s1_hc_q == '0);
    vc_zero   = (s1_vc_q == '0);
    above_m   = above_raw & ~vc_zero;
    left_m    = s1_left_q & ~hc_zero;
    al_m      = s1_al_q & ~hc_zero & ~vc_zero;
    win_n     = win_cnt_t'(s1_b_q) + win_cnt_t'(left_m) + win_cnt_t'(above_m)
              + win_cnt_t'(al_m);
    taps      = taps_for(hc_zero, vc_zero);
    gray_calc = (taps == Taps1) ? ((win_n != '0) ? ON : OFF) : sat_scale(win_n, taps);

    out_valid_d = s1_valid_q;
    gray_d      = gray_q;
    hc_out_d    = hc_out_q;
    vc_out_d    = vc_out_q;
    if (s1_valid_q) begin
      gray_d   = gray_calc;
      hc_out_d = s1_hc_q;
      vc_out_d = s1_vc_q;
    end
  end

  // Pipeline and tap registers; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_b_q    <= 1'b0;
      have_prev_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_b_q      <= 1'b0;
      s1_left_q   <= 1'b0;
      s1_al_q     <= 1'b0;
      s1_hc_q     <= '0;
      s1_vc_q     <= '0;
      out_valid_q <= 1'b0;
      gray_q      <= '0;
      hc_out_q    <= '0;
      vc_out_q    <= '0;
    end else begin
      prev_b_q    <= prev_b_d;
      have_prev_q <= have_prev_d;
      s1_valid_q  <= s1_valid_d;
      s1_b_q      <= s1_b_d;
      s1_left_q   <= s1_left_d;
      s1_al_q     <= s1_al_d;
      s1_hc_q     <= s1_hc_d;
      s1_vc_q     <= s1_vc_d;
      out_valid_q <= out_valid_d;
      gray_q      <= gray_d;
      hc_out_q    <= hc_out_d;
      vc_out_q    <= vc_out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.gray_out  = gray_q;
  assign bus.hc_out    = hc_out_q;
  assign bus.vc_out    = vc_out_q;

endmodule

// File: tb/tb_dither_reconstruct.sv
// Directed bench for dither_reconstruct with an 8-pixel line.
module tb_dither_reconstruct;

  localparam int unsigned LineW = 8;

  logic clk;
  logic reset;

  dither_reconstruct_if bus ();

  dither_reconstruct #(
    .LINE_W (LineW),
    .THRESH (8'd128),
    .ON     (8'd255),
    .OFF    (8'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [7:0]  pix;
    logic        exp_valid;
    logic [7:0]  exp_gray;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic valid, int hc, int vc, int pix, logic exp_valid, int gray);
    vec_t v;
    v.valid     = valid;
    v.hc        = 11'(hc);
    v.vc        = 11'(vc);
    v.pix       = 8'(pix);
    v.exp_valid = exp_valid;
    v.exp_gray  = 8'(gray);
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input int hc, input int vc, input int pix);
    bus.pix_valid = valid;
    bus.hc        = 11'(hc);
    bus.vc        = 11'(vc);
    bus.pixel_in  = 8'(pix);
  endtask

  // Stream the table back-to-back; output for vector k is due one edge after its accept edge
  task automatic run_vectors();
    int n;
    n = vq.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) drive(vq[k].valid, int'(vq[k].hc), int'(vq[k].vc), int'(vq[k].pix));
      else       drive(1'b0, 0, 0, 0);
      @(posedge clk);
      #1;
      if (k >= 1) begin
        check($sformatf("vec%0d out_valid", k - 1), bus.out_valid, vq[k-1].exp_valid);
        if (vq[k-1].exp_valid) begin
          check($sformatf("vec%0d gray(%0d,%0d)", k - 1, vq[k-1].hc, vq[k-1].vc),
                bus.gray_out, vq[k-1].exp_gray);
          check($sformatf("vec%0d hc_out", k - 1), bus.hc_out, vq[k-1].hc);
          check($sformatf("vec%0d vc_out", k - 1), bus.vc_out, vq[k-1].vc);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 0, 0, 0);

    // Reset held 3 clk, released with no input
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", bus.out_valid, 0);
    check("reset gray", bus.gray_out, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle%0d out_valid", i), bus.out_valid, 0);
      check($sformatf("idle%0d gray", i), bus.gray_out, 0);
      check($sformatf("idle%0d hc_out", i), bus.hc_out, 0);
      check($sformatf("idle%0d vc_out", i), bus.vc_out, 0);
    end

    // All-on frame: every window saturates to 255
    for (int vc = 0; vc < 3; vc++)
      for (int hc = 0; hc < 4; hc++)
        add(1'b1, hc, vc, 255, 1'b1, 255);

    // Checkerboard: 255 at origin, 128 everywhere else
    for (int vc = 0; vc < 3; vc++)
      for (int hc = 0; hc < 4; hc++)
        add(1'b1, hc, vc, (((hc ^ vc) & 1) == 0) ? 255 : 0, 1'b1,
            (hc == 0 && vc == 0) ? 255 : 128);

    // Single on pixel at (3,2) at threshold level, background just below threshold
    for (int vc = 0; vc < 4; vc++)
      for (int hc = 0; hc < 5; hc++) begin
        add(1'b1, hc, vc, (hc == 3 && vc == 2) ? 128 : 127, 1'b1,
            ((hc == 3 || hc == 4) && (vc == 2 || vc == 3)) ? 64 : 0);
        if (hc == 3 && vc == 2) add(1'b0, 4, 2, 0, 1'b0, 0);
      end

    // Out-of-line pixels mid-row must not disturb taps, buffer or output
    add(1'b1, 0, 0, 255, 1'b1, 255);
    add(1'b1, 1, 0, 255, 1'b1, 255);
    add(1'b1, LineW + 5, 0, 0, 1'b0, 0);
    add(1'b1, 2, 0, 255, 1'b1, 255);
    add(1'b1, LineW, 0, 0, 1'b0, 0);
    add(1'b1, 3, 0, 255, 1'b1, 255);
    add(1'b1, 0, 1, 0, 1'b1, 128);
    add(1'b1, 1, 1, 0, 1'b1, 128);
    add(1'b1, 2, 1, 0, 1'b1, 128);
    add(1'b1, 3, 1, 0, 1'b1, 128);

    run_vectors();

    // Reset pulse between two back-to-back pixels drops both
    drive(1'b1, 0, 0, 255);
    @(posedge clk);
    #1;
    drive(1'b1, 1, 0, 255);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstpulse A out_valid", bus.out_valid, 0);
    check("rstpulse gray cleared", bus.gray_out, 0);
    reset = 1'b0;
    drive(1'b0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rstpulse quiet%0d out_valid", i), bus.out_valid, 0);
    end
    // Next pixel at hc=0 on row 1: only the above bit written by A counts
    drive(1'b1, 0, 1, 0);
    @(posedge clk);
    #1;
    drive(1'b0, 0, 0, 0);
    check("rstpulse C early out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("rstpulse C out_valid", bus.out_valid, 1);
    check("rstpulse C gray", bus.gray_out, 128);
    check("rstpulse C vc_out", bus.vc_out, 1);
    @(posedge clk);
    #1;
    check("rstpulse C single pulse", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
